// File: rtl/router_pkg.sv
// Shared encodings and header helpers for the multi-link router controller.
package router_pkg;

    localparam int unsigned ST_W = 4;

    localparam logic [ST_W-1:0] ST_IDLE       = 4'd0;
    localparam logic [ST_W-1:0] ST_ARB_REQ    = 4'd1;
    localparam logic [ST_W-1:0] ST_ARB_DLY    = 4'd2;
    localparam logic [ST_W-1:0] ST_ENC_START  = 4'd3;
    localparam logic [ST_W-1:0] ST_ENC_WAIT   = 4'd4;
    localparam logic [ST_W-1:0] ST_HDR_DECODE = 4'd5;
    localparam logic [ST_W-1:0] ST_STREAM     = 4'd6;
    localparam logic [ST_W-1:0] ST_DROP       = 4'd7;
    localparam logic [ST_W-1:0] ST_DONE       = 4'd8;

    // What the packet currently in flight is doing; selects source, target and done pulse.
    localparam logic [1:0] MODE_LOCAL = 2'd0;
    localparam logic [1:0] MODE_FWD   = 2'd1;
    localparam logic [1:0] MODE_DLV   = 2'd2;
    localparam logic [1:0] MODE_DROP  = 2'd3;

    // Header fields are packed downward from the beat MSB: TTL, dst ID, src ID.
    localparam int unsigned HDR_TTL_POS = 0;

    localparam int unsigned STAT_W = 16;

    function automatic int unsigned hdr_dst_pos(input int unsigned ttl_w);
        return ttl_w;
    endfunction

    function automatic int unsigned hdr_src_pos(input int unsigned ttl_w, input int unsigned rid_w);
        return ttl_w + rid_w;
    endfunction

    function automatic int unsigned egress_index(input int unsigned dst_id, input int unsigned num_links);
        return dst_id % num_links;
    endfunction

endpackage

// File: rtl/router_rr_arbiter.sv
// Round-robin arbiter over NUM_REQ requesters; the pointer moves past the winner on advance.
module router_rr_arbiter
    import router_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    input  logic [IDX_W-1:0]   advance_idx,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = IDX_W'((32'(ptr) + off) % NUM_REQ);
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (advance_idx == IDX_W'(NUM_REQ - 1)) ? '0 : advance_idx + 1'b1;
        end
    end

endmodule

// File: rtl/router_controller_mp.sv
// Whole-packet scheduler: local source plus NUM_LINKS ingress links steered through the crossbar.
// Optional traffic counters are built when ROUTER_CTRL_STATS_EN is defined.
module router_controller_mp
    import router_pkg::*;
#(
    parameter int unsigned AURORA_DATA_WIDTH      = 64,
    parameter int unsigned ADDR_WIDTH             = 10,
    parameter int unsigned NUMBER_PACKET          = 19,
    parameter int unsigned NUM_LINKS              = 2,
    parameter int unsigned RECOGNIZE_ROUTER_WIDTH = 2,
    parameter int unsigned ROUTER_ID              = 0,
    parameter int unsigned TTL_WIDTH              = 2,
    parameter int unsigned TTL_INIT               = 3
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   router_start_req,
    input  logic [ADDR_WIDTH-1:0]                  router_scr_addr,
    input  logic [ADDR_WIDTH-1:0]                  router_dst_addr,
    input  logic [RECOGNIZE_ROUTER_WIDTH-1:0]      router_dst_id,
    output logic                                   router_done,
    output logic                                   arbiter_read_req,
    input  logic                                   arbiter_read_gnt,
    output logic [ADDR_WIDTH-1:0]                  arbiter_src_addr,
    output logic [ADDR_WIDTH-1:0]                  arbiter_dst_addr,
    output logic                                   start_encap_pkt,
    output logic [9+TTL_WIDTH-1:0]                 header_pkt_send,
    input  logic                                   empty_input_port_0,
    output logic                                   rd_input_port_0,
    input  logic [NUM_LINKS-1:0]                   link_empty,
    output logic [NUM_LINKS-1:0]                   link_rd,
    input  logic [NUM_LINKS*AURORA_DATA_WIDTH-1:0] link_hdr,
    input  logic [NUM_LINKS-1:0]                   link_full,
    output logic [NUM_LINKS-1:0]                   link_we,
    output logic                                   we_output_port_0,
    input  logic                                   full_output_port_0,
    output logic                                   start_decap_pkt,
    output logic [$clog2(NUM_LINKS+1)-1:0]         control_crossbar,
    output logic                                   hdr_ttl_dec
`ifdef ROUTER_CTRL_STATS_EN
    ,
    output logic [STAT_W-1:0]                      stat_fwd,
    output logic [STAT_W-1:0]                      stat_dlv,
    output logic [STAT_W-1:0]                      stat_drop,
    output logic [STAT_W-1:0]                      stat_local
`endif
);

    localparam int unsigned W    = AURORA_DATA_WIDTH;
    localparam int unsigned RW   = RECOGNIZE_ROUTER_WIDTH;
    localparam int unsigned TW   = TTL_WIDTH;
    localparam int unsigned NSRC = NUM_LINKS + 1;
    localparam int unsigned CW   = $clog2(NSRC);
    localparam int unsigned LW   = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1;
    localparam int unsigned BW   = $clog2(NUMBER_PACKET);
    localparam int unsigned HW   = TW + RW;
    localparam int unsigned HP_W = 9 + TW;

    localparam logic [TW-1:0] TTL_INIT_V  = TW'(TTL_INIT);
    localparam logic [RW-1:0] ROUTER_ID_V = RW'(ROUTER_ID);
    localparam logic [BW-1:0] LAST_BEAT   = BW'(NUMBER_PACKET - 1);

    logic [ST_W-1:0] state;
    logic [1:0]      mode;
    logic [LW-1:0]   src_link;
    logic [LW-1:0]   egress;
    logic [BW-1:0]   beat_cnt;
    logic [HW-1:0]   hdr_q;
    logic [W-1:0]    hdr_sel;
    logic [TW-1:0]   hdr_ttl;
    logic [RW-1:0]   hdr_dst;

    logic [NSRC-1:0] rr_req;
    logic [NSRC-1:0] rr_gnt;
    logic [CW-1:0]   rr_idx;
    logic            rr_valid;

    logic src_empty;
    logic tgt_full;
    logic xfer;
    logic unused_bits;

    assign rr_req = {~link_empty, router_start_req};

    router_rr_arbiter #(
        .NUM_REQ (NSRC),
        .IDX_W   (CW)
    ) u_rr (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (rr_req),
        .advance     (state == ST_DONE),
        .advance_idx (control_crossbar),
        .gnt         (rr_gnt),
        .gnt_idx     (rr_idx),
        .gnt_valid   (rr_valid)
    );

    // Head-of-FIFO beat of the winning link, captured while the FIFO still presents it.
    always_comb begin
        hdr_sel = '0;
        for (int unsigned i = 0; i < NUM_LINKS; i++) begin
            if (rr_gnt[i+1]) hdr_sel = link_hdr[i*W +: W];
        end
    end

    assign hdr_ttl     = hdr_q[HW-1-HDR_TTL_POS -: TW];
    assign hdr_dst     = hdr_q[HW-1-hdr_dst_pos(TW) -: RW];
    assign unused_bits = ^{hdr_sel[W-HW-1:0], rr_gnt[0]};

    always_comb begin
        src_empty = 1'b1;
        if (mode == MODE_LOCAL) begin
            src_empty = empty_input_port_0;
        end else begin
            for (int unsigned i = 0; i < NUM_LINKS; i++) begin
                if (src_link == LW'(i)) src_empty = link_empty[i];
            end
        end
    end

    always_comb begin
        tgt_full = 1'b0;
        case (mode)
            MODE_LOCAL, MODE_FWD: begin
                for (int unsigned i = 0; i < NUM_LINKS; i++) begin
                    if (egress == LW'(i)) tgt_full = link_full[i];
                end
            end
            MODE_DLV: tgt_full = full_output_port_0;
            default:  tgt_full = 1'b0;
        endcase
    end

    // A beat moves only when both ends are ready; DROP has no target so only the source matters.
    assign xfer = ((state == ST_STREAM) && !src_empty && !tgt_full) ||
                  ((state == ST_DROP) && !src_empty);

    always_comb begin
        link_rd = '0;
        link_we = '0;
        for (int unsigned i = 0; i < NUM_LINKS; i++) begin
            link_rd[i] = xfer && (mode != MODE_LOCAL) && (src_link == LW'(i));
            link_we[i] = xfer && (state == ST_STREAM) &&
                         ((mode == MODE_LOCAL) || (mode == MODE_FWD)) && (egress == LW'(i));
        end
    end

    assign rd_input_port_0  = xfer && (mode == MODE_LOCAL);
    assign we_output_port_0 = xfer && (mode == MODE_DLV);
    assign hdr_ttl_dec      = xfer && (mode == MODE_FWD) && (beat_cnt == '0);
    assign arbiter_read_req = (state == ST_ARB_REQ);
    assign start_encap_pkt  = (state == ST_ENC_START);
    assign router_done      = (state == ST_DONE) && (mode == MODE_LOCAL);
    assign start_decap_pkt  = (state == ST_DONE) && (mode == MODE_DLV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            mode             <= MODE_LOCAL;
            src_link         <= '0;
            egress           <= '0;
            beat_cnt         <= '0;
            hdr_q            <= '0;
            control_crossbar <= '0;
            arbiter_src_addr <= '0;
            arbiter_dst_addr <= '0;
            header_pkt_send  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rr_valid) begin
                        control_crossbar <= rr_idx;
                        if (rr_idx == '0) begin
                            mode             <= MODE_LOCAL;
                            arbiter_src_addr <= router_scr_addr;
                            arbiter_dst_addr <= router_dst_addr;
                            header_pkt_send  <= HP_W'({TTL_INIT_V, ROUTER_ID_V, router_dst_id, 5'b0});
                            egress           <= LW'(egress_index(32'(router_dst_id), NUM_LINKS));
                            state            <= ST_ARB_REQ;
                        end else begin
                            src_link <= LW'(rr_idx - 1'b1);
                            hdr_q    <= hdr_sel[W-1 -: HW];
                            state    <= ST_HDR_DECODE;
                        end
                    end
                end
                ST_ARB_REQ:   if (arbiter_read_gnt) state <= ST_ARB_DLY;
                ST_ARB_DLY:   state <= ST_ENC_START;
                ST_ENC_START: state <= ST_ENC_WAIT;
                ST_ENC_WAIT:  if (!empty_input_port_0) state <= ST_STREAM;
                ST_HDR_DECODE: begin
                    if (hdr_dst == ROUTER_ID_V) begin
                        mode  <= MODE_DLV;
                        state <= ST_STREAM;
                    end else if (hdr_ttl == '0) begin
                        mode  <= MODE_DROP;
                        state <= ST_DROP;
                    end else begin
                        mode   <= MODE_FWD;
                        egress <= LW'(egress_index(32'(hdr_dst), NUM_LINKS));
                        state  <= ST_STREAM;
                    end
                end
                ST_STREAM, ST_DROP: begin
                    if (xfer) begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            state    <= ST_DONE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ROUTER_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fwd   <= '0;
            stat_dlv   <= '0;
            stat_drop  <= '0;
            stat_local <= '0;
        end else if (state == ST_DONE) begin
            case (mode)
                MODE_FWD:   if (stat_fwd   != '1) stat_fwd   <= stat_fwd   + 1'b1;
                MODE_DLV:   if (stat_dlv   != '1) stat_dlv   <= stat_dlv   + 1'b1;
                MODE_DROP:  if (stat_drop  != '1) stat_drop  <= stat_drop  + 1'b1;
                default:    if (stat_local != '1) stat_local <= stat_local + 1'b1;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_router_controller_mp.sv
// Directed bench for router_controller_mp: local send, forward, deliver, drop, reset, contention.
module tb_router_controller_mp;

    localparam int W  = 64;
    localparam int AW = 10;
    localparam int NP = 19;
    localparam int NL = 2;
    localparam int RW = 2;
    localparam int TW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            router_start_req;
    logic [AW-1:0]   router_scr_addr;
    logic [AW-1:0]   router_dst_addr;
    logic [RW-1:0]   router_dst_id;
    logic            router_done;
    logic            arbiter_read_req;
    logic            arbiter_read_gnt;
    logic [AW-1:0]   arbiter_src_addr;
    logic [AW-1:0]   arbiter_dst_addr;
    logic            start_encap_pkt;
    logic [8+TW:0]   header_pkt_send;
    logic            empty_input_port_0;
    logic            rd_input_port_0;
    logic [NL-1:0]   link_empty;
    logic [NL-1:0]   link_rd;
    logic [NL*W-1:0] link_hdr;
    logic [NL-1:0]   link_full;
    logic [NL-1:0]   link_we;
    logic            we_output_port_0;
    logic            full_output_port_0;
    logic            start_decap_pkt;
    logic [1:0]      control_crossbar;
    logic            hdr_ttl_dec;
`ifdef ROUTER_CTRL_STATS_EN
    logic [15:0]     stat_fwd, stat_dlv, stat_drop, stat_local;
`endif

    router_controller_mp #(
        .AURORA_DATA_WIDTH      (W),
        .ADDR_WIDTH             (AW),
        .NUMBER_PACKET          (NP),
        .NUM_LINKS              (NL),
        .RECOGNIZE_ROUTER_WIDTH (RW),
        .ROUTER_ID              (0),
        .TTL_WIDTH              (TW),
        .TTL_INIT               (3)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .router_start_req   (router_start_req),
        .router_scr_addr    (router_scr_addr),
        .router_dst_addr    (router_dst_addr),
        .router_dst_id      (router_dst_id),
        .router_done        (router_done),
        .arbiter_read_req   (arbiter_read_req),
        .arbiter_read_gnt   (arbiter_read_gnt),
        .arbiter_src_addr   (arbiter_src_addr),
        .arbiter_dst_addr   (arbiter_dst_addr),
        .start_encap_pkt    (start_encap_pkt),
        .header_pkt_send    (header_pkt_send),
        .empty_input_port_0 (empty_input_port_0),
        .rd_input_port_0    (rd_input_port_0),
        .link_empty         (link_empty),
        .link_rd            (link_rd),
        .link_hdr           (link_hdr),
        .link_full          (link_full),
        .link_we            (link_we),
        .we_output_port_0   (we_output_port_0),
        .full_output_port_0 (full_output_port_0),
        .start_decap_pkt    (start_decap_pkt),
        .control_crossbar   (control_crossbar),
        .hdr_ttl_dec        (hdr_ttl_dec)
`ifdef ROUTER_CTRL_STATS_EN
        ,
        .stat_fwd           (stat_fwd),
        .stat_dlv           (stat_dlv),
        .stat_drop          (stat_drop),
        .stat_local         (stat_local)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Event counters sampled mid-cycle; tests take snapshots and compare deltas.
    int n_lwe0 = 0, n_lwe1 = 0, n_lrd0 = 0, n_lrd1 = 0, n_weo = 0;
    int n_rdi = 0, n_done = 0, n_decap = 0, n_encap = 0, n_ttl = 0;
    int s_lwe0, s_lwe1, s_lrd0, s_lrd1, s_weo, s_rdi, s_done, s_decap, s_encap, s_ttl;

    always @(negedge clk) begin
        if (rst_n) begin
            n_lwe0  += int'(link_we[0]);
            n_lwe1  += int'(link_we[1]);
            n_lrd0  += int'(link_rd[0]);
            n_lrd1  += int'(link_rd[1]);
            n_weo   += int'(we_output_port_0);
            n_rdi   += int'(rd_input_port_0);
            n_done  += int'(router_done);
            n_decap += int'(start_decap_pkt);
            n_encap += int'(start_encap_pkt);
            n_ttl   += int'(hdr_ttl_dec);
        end
    end

    task automatic snap();
        s_lwe0 = n_lwe0; s_lwe1 = n_lwe1; s_lrd0 = n_lrd0; s_lrd1 = n_lrd1; s_weo = n_weo;
        s_rdi = n_rdi; s_done = n_done; s_decap = n_decap; s_encap = n_encap; s_ttl = n_ttl;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Plays one source FIFO through a packet: counts pops, optionally stalls egress link 1,
    // and empties the source after the last beat so no second packet is offered.
    task automatic drive_pkt(input int src, input int stop_at, input int stall_at, input int stall_len,
                             output int pops, output int viol, output int ttl_first, output int sel);
        int left;
        bit stalled;
        bit got;
        pops = 0; viol = 0; ttl_first = 0; sel = -1; left = 0; stalled = 0;
        for (int c = 0; c < 400 && pops < stop_at; c++) begin
            @(negedge clk);
            if (left > 0 && (link_rd != '0 || link_we != '0 || rd_input_port_0 || we_output_port_0))
                viol++;
            got = (src == 0) ? rd_input_port_0 : link_rd[src-1];
            if (got) begin
                if (pops == 0) begin
                    ttl_first = int'(hdr_ttl_dec);
                    sel       = int'(control_crossbar);
                end
                pops++;
            end
            @(posedge clk);
            #1;
            if (left > 0) begin
                left--;
                if (left == 0) link_full[1] = 1'b0;
            end else if (stall_len > 0 && !stalled && pops == stall_at) begin
                link_full[1] = 1'b1;
                left         = stall_len;
                stalled      = 1'b1;
            end
            if (pops == NP) begin
                if (src == 0) begin
                    empty_input_port_0 = 1'b1;
                    router_start_req   = 1'b0;
                end else begin
                    link_empty[src-1] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops, viol, ttlf, sel;
        int pa, pb, pc, va, vb, vc, ta, tb, tc, sa, sb, sc;

        rst_n = 1'b0;
        router_start_req = 1'b0;
        router_scr_addr = '0;
        router_dst_addr = '0;
        router_dst_id = '0;
        arbiter_read_gnt = 1'b0;
        empty_input_port_0 = 1'b1;
        link_empty = '1;
        link_hdr = '0;
        link_full = '0;
        full_output_port_0 = 1'b0;

        // Reset state
        run(3);
        @(negedge clk);
        chk("rst_read_req", arbiter_read_req, 0);
        chk("rst_link_we", link_we, 0);
        chk("rst_link_rd", link_rd, 0);
        chk("rst_xbar", control_crossbar, 0);
        chk("rst_header", header_pkt_send, 0);
        chk("rst_done", router_done, 0);
        run(1);
        rst_n = 1'b1;
        run(2);

        // Local send
        snap();
        router_start_req = 1'b1;
        router_scr_addr  = 10'h010;
        router_dst_addr  = 10'h200;
        router_dst_id    = 2'd1;
        run(1);
        @(negedge clk);
        chk("loc_read_req", arbiter_read_req, 1);
        chk("loc_src_addr", arbiter_src_addr, 10'h010);
        chk("loc_dst_addr", arbiter_dst_addr, 10'h200);
        chk("loc_header", header_pkt_send, 11'h620);
        chk("loc_hdr_ttl", header_pkt_send[10:9], 3);
        chk("loc_xbar", control_crossbar, 0);
        router_start_req = 1'b0;
        run(3);
        arbiter_read_gnt = 1'b1;
        @(negedge clk);
        chk("loc_req_held", arbiter_read_req, 1);
        chk("loc_encap_early", start_encap_pkt, 0);
        run(1);
        arbiter_read_gnt = 1'b0;
        @(negedge clk);
        chk("loc_dly_req", arbiter_read_req, 0);
        chk("loc_dly_encap", start_encap_pkt, 0);
        run(1);
        @(negedge clk);
        chk("loc_encap", start_encap_pkt, 1);
        empty_input_port_0 = 1'b0;
        drive_pkt(0, NP, 0, 0, pops, viol, ttlf, sel);
        run(3);
        chk("loc_pops", pops, NP);
        chk("loc_we1", n_lwe1 - s_lwe1, NP);
        chk("loc_we0", n_lwe0 - s_lwe0, 0);
        chk("loc_done", n_done - s_done, 1);
        chk("loc_encap_cnt", n_encap - s_encap, 1);
        chk("loc_ttl_dec", n_ttl - s_ttl, 0);

        // Transit forward: link0, TTL=2, dst=1
        snap();
        link_hdr[63:0] = {2'd2, 2'd1, 2'd1, 58'h0};
        link_empty = 2'b10;
        drive_pkt(1, NP, 0, 0, pops, viol, ttlf, sel);
        run(3);
        chk("fwd_pops", pops, NP);
        chk("fwd_sel", sel, 1);
        chk("fwd_we1", n_lwe1 - s_lwe1, NP);
        chk("fwd_we0", n_lwe0 - s_lwe0, 0);
        chk("fwd_weo", n_weo - s_weo, 0);
        chk("fwd_ttl_first", ttlf, 1);
        chk("fwd_ttl_cnt", n_ttl - s_ttl, 1);

        // Delivery: link1, dst=0
        snap();
        link_hdr[127:64] = {2'd1, 2'd0, 2'd1, 58'h0};
        link_empty = 2'b01;
        drive_pkt(2, NP, 0, 0, pops, viol, ttlf, sel);
        run(3);
        chk("dlv_pops", pops, NP);
        chk("dlv_sel", sel, 2);
        chk("dlv_weo", n_weo - s_weo, NP);
        chk("dlv_link_we", (n_lwe0 - s_lwe0) + (n_lwe1 - s_lwe1), 0);
        chk("dlv_decap", n_decap - s_decap, 1);
        chk("dlv_done", n_done - s_done, 0);

        // TTL expiry on link0, with every target full
        snap();
        link_hdr[63:0] = {2'd0, 2'd2, 2'd1, 58'h0};
        link_full = 2'b11;
        full_output_port_0 = 1'b1;
        link_empty = 2'b10;
        drive_pkt(1, NP, 0, 0, pops, viol, ttlf, sel);
        run(3);
        chk("drop_pops", pops, NP);
        chk("drop_rd0", n_lrd0 - s_lrd0, NP);
        chk("drop_link_we", (n_lwe0 - s_lwe0) + (n_lwe1 - s_lwe1), 0);
        chk("drop_weo", n_weo - s_weo, 0);
        chk("drop_decap", n_decap - s_decap, 0);
        link_full = '0;
        full_output_port_0 = 1'b0;
`ifdef ROUTER_CTRL_STATS_EN
        chk("stat_drop", stat_drop, 1);
        chk("stat_fwd", stat_fwd, 1);
        chk("stat_dlv", stat_dlv, 1);
        chk("stat_local", stat_local, 1);
`endif

        // Reset in the middle of a forwarded packet
        link_hdr[63:0] = {2'd2, 2'd1, 2'd1, 58'h0};
        link_empty = 2'b10;
        drive_pkt(1, 7, 0, 0, pops, viol, ttlf, sel);
        chk("mid_pops", pops, 7);
        rst_n = 1'b0;
        link_empty = '1;
        #1;
        chk("mid_rst_rd", link_rd, 0);
        chk("mid_rst_we", link_we, 0);
        chk("mid_rst_xbar", control_crossbar, 0);
        chk("mid_rst_ttl", hdr_ttl_dec, 0);
        @(negedge clk);
        chk("mid_rst_we_neg", link_we, 0);
`ifdef ROUTER_CTRL_STATS_EN
        chk("mid_rst_stat", stat_drop, 0);
`endif
        run(1);
        rst_n = 1'b1;
        run(1);

        // Contention: local, link0 and link1 all pending; egress link1 stalls mid link0 packet
        snap();
        router_start_req   = 1'b1;
        router_dst_id      = 2'd1;
        router_scr_addr    = 10'h033;
        router_dst_addr    = 10'h144;
        arbiter_read_gnt   = 1'b1;
        empty_input_port_0 = 1'b0;
        link_hdr[63:0]     = {2'd2, 2'd1, 2'd1, 58'h0};
        link_hdr[127:64]   = {2'd1, 2'd0, 2'd1, 58'h0};
        link_empty         = 2'b00;
        drive_pkt(0, NP, 0, 0, pa, va, ta, sa);
        drive_pkt(1, NP, 8, 5, pb, vb, tb, sb);
        drive_pkt(2, NP, 0, 0, pc, vc, tc, sc);
        run(3);
        arbiter_read_gnt = 1'b0;
        chk("cont_sel_first", sa, 0);
        chk("cont_sel_second", sb, 1);
        chk("cont_sel_third", sc, 2);
        chk("cont_pops_local", pa, NP);
        chk("cont_pops_link0", pb, NP);
        chk("cont_pops_link1", pc, NP);
        chk("cont_stall_quiet", vb, 0);
        chk("cont_ttl_beat0", tb, 1);
        chk("cont_we1", n_lwe1 - s_lwe1, 2 * NP);
        chk("cont_weo", n_weo - s_weo, NP);
        chk("cont_done", n_done - s_done, 1);
        chk("cont_decap", n_decap - s_decap, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/router_controller_mp.md
Name: router_controller_mp

Overview:
- Parametrised successor to the single-link router controller.
- Schedules whole packets from one local source and NUM_LINKS Aurora ingress FIFOs.
- Local source: arbiter-granted memory read followed by packet encapsulation.
- Per packet, steers the crossbar to one of three destinations: an egress link FIFO (forward), the local output FIFO (deliver, then decapsulate), or nowhere (drop on TTL expiry).
- Sits between the total controller/arbiter and the crossbar/port FIFOs.

Parameters:
- AURORA_DATA_WIDTH, 64, beat width.
- ADDR_WIDTH, 10, memory address width.
- NUMBER_PACKET, 19, beats per packet including the header beat.
- NUM_LINKS, 2, number of Aurora ingress/egress link pairs (1..8).
- RECOGNIZE_ROUTER_WIDTH, 2, router ID width.
- ROUTER_ID, 0, this router's ID.
- TTL_WIDTH, 2, TTL field width.
- TTL_INIT, 3, TTL written into locally originated headers.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- router_start_req  in  1  local transfer request (level)
- router_scr_addr  in  ADDR_WIDTH  local source address
- router_dst_addr  in  ADDR_WIDTH  destination address
- router_dst_id  in  RECOGNIZE_ROUTER_WIDTH  destination router
- router_done  out  1  one-cycle pulse, local packet fully sent
- arbiter_read_req  out  1  read request
- arbiter_read_gnt  in  1  read grant
- arbiter_src_addr  out  ADDR_WIDTH  latched source address
- arbiter_dst_addr  out  ADDR_WIDTH  latched destination address
- start_encap_pkt  out  1  one-cycle pulse
- header_pkt_send  out  9+TTL_WIDTH  {TTL_INIT, ROUTER_ID, router_dst_id, 5'b0} low-justified
- empty_input_port_0  in  1  local encap FIFO empty
- rd_input_port_0  out  1  local FIFO pop
- link_empty  in  NUM_LINKS  ingress FIFO empties
- link_rd  out  NUM_LINKS  ingress pops (one-hot or zero)
- link_hdr  in  NUM_LINKS*AURORA_DATA_WIDTH  head-of-FIFO data (FWFT)
- link_full  in  NUM_LINKS  egress FIFO fulls
- link_we  out  NUM_LINKS  egress writes (one-hot or zero)
- we_output_port_0  out  1  local output FIFO write
- full_output_port_0  in  1  local output FIFO full
- start_decap_pkt  out  1  one-cycle pulse after a delivered packet
- control_crossbar  out  $clog2(NUM_LINKS+1)  source select (0 local, k link k-1)
- hdr_ttl_dec  out  1  crossbar decrements TTL on the current beat

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer 0; beat counter 0.
- Header (beat 0) fields:
  - TTL = [W-1 -: TTL_WIDTH].
  - dst ID = next RECOGNIZE_ROUTER_WIDTH bits.
  - src ID = the following RECOGNIZE_ROUTER_WIDTH bits.
- Arbitration in IDLE:
  - Candidates: local (router_start_req) and each link with !link_empty.
  - Round-robin starts at the pointer; the pointer advances to winner+1 (mod NUM_LINKS+1) when the packet finishes.
  - The winner's index is latched into control_crossbar.
- Local path (state sequence): ARB_REQ → ARB_DLY → ENC_START → ENC_WAIT → STREAM → DONE → IDLE.
  - ARB_REQ asserts arbiter_read_req until gnt. Addresses are latched on entry.
  - ARB_DLY lasts 1 cycle.
  - ENC_START pulses start_encap_pkt for 1 cycle.
  - ENC_WAIT holds until !empty_input_port_0.
  - The egress link is router_dst_id mod NUM_LINKS.
- Link path: HDR_DECODE lasts 1 cycle on the latched header, then branches:
  - dst==ROUTER_ID: deliver to local output, then STREAM.
  - TTL==0: DROP (pop all beats, no write).
  - Otherwise: forward to egress (dst mod NUM_LINKS), hdr_ttl_dec=1 on beat 0, then STREAM.
- Beat transfer:
  - rd and we are asserted in the same cycle, only when the source is !empty and the target is !full.
  - Otherwise the controller stalls; there is no bubble penalty and no timeout.
  - The beat counter increments per transfer; at NUMBER_PACKET-1 it wraps to 0 and the FSM moves to DONE.
  - DROP ignores full.
- DONE (1 cycle):
  - Local packet: router_done=1.
  - Delivered packet: start_decap_pkt=1.
  - Then IDLE. A new arbitration takes place in the following cycle.
- Simultaneous local and link requests: the round-robin pointer decides. The link never preempts a packet in flight.
- Reset mid-packet: immediate return to IDLE. The partial packet is abandoned; upstream flushing is the system's responsibility.

Optional Feature:
- Macro ROUTER_CTRL_STATS_EN.
- With it: adds outputs stat_fwd, stat_dlv, stat_drop, stat_local, each 16 bits, saturating, incremented in DONE/DROP completion; cleared by reset.
- Without it: these ports and counters are absent.

Decomposition:
- Package router_pkg holds:
  - state encoding (localparam enum);
  - header field offset/width localparams;
  - helper function computing the egress index.
- One sub-module, router_rr_arbiter: parametrised round-robin over NUM_LINKS+1 requests; outputs a one-hot grant plus index; pointer update on an advance strobe.

Test Plan:
- Local send: start_req=1, src=0x010, dst=0x200, dst_id=1, gnt after 3 cycles → start_encap pulse 2 cycles after gnt; 19 link_we[1] writes; router_done pulses once; header TTL=3.
- Transit forward: link0 header TTL=2, dst=1, ROUTER_ID=0 → 19 beats to link_we[1]; hdr_ttl_dec=1 only on beat 0.
- Delivery: link1 header dst=0 → 19 we_output_port_0 writes, then start_decap_pkt pulse; no link_we.
- TTL expiry: link0 header TTL=0, dst=2 → 19 link_rd[0] pops; zero writes; STATS build: stat_drop=1.
- Contention and backpressure: local request and link0 and link1 all pending → service order local, link0, link1. Hold link_full[1]=1 for 5 cycles mid-packet → no rd/we during the stall; beat count stays 19.
- Reset mid-stream at beat 7 → all outputs 0 next cycle; the next packet starts at beat 0.
